// File: rtl/rle_pkg.sv
// Shared constants and state encoding for the RLE encode/decode path.
// Run word layout: [BIT_ID] = bit value, [CNT_MSB:0] = run length.
package rle_pkg;
  localparam int WORD_W  = 24;
  localparam int CNT_W   = 23;
  localparam int BYTE_W  = 8;
  localparam int BIT_ID  = 23;
  localparam int CNT_MSB = 22;
  localparam int FILL_W  = 4;

  typedef enum logic [3:0] {
    IDLE, REQ, WAIT, LOAD, FILL, WRITE, WACK, FLUSH, DONE
  } state_t;
endpackage

// File: rtl/rle_bit_packer.sv
// One packing step: drops up to (8 - fill) copies of cur_bit into pack,
// starting at bit position fill (LSB-first).
// Ports:
//   pack, fill, remaining, cur_bit         - current packer/run state
//   next_pack, next_fill, next_remaining   - state after one step
module rle_bit_packer
  import rle_pkg::*;
(
  input  logic [BYTE_W-1:0] pack,
  input  logic [FILL_W-1:0] fill,
  input  logic [CNT_W-1:0]  remaining,
  input  logic              cur_bit,
  output logic [BYTE_W-1:0] next_pack,
  output logic [FILL_W-1:0] next_fill,
  output logic [CNT_W-1:0]  next_remaining
);
  logic [CNT_W-1:0] space, n, lo, hi;

  always_comb begin
    // fill is 0..8, so space never underflows
    lo             = {{(CNT_W-FILL_W){1'b0}}, fill};
    space          = CNT_W'(BYTE_W) - lo;
    n              = (remaining < space) ? remaining : space;
    hi             = lo + n;
    next_fill      = fill + n[FILL_W-1:0];
    next_remaining = remaining - n;
    next_pack      = pack;
    for (int i = 0; i < BYTE_W; i++) begin
      if (CNT_W'(i) >= lo && CNT_W'(i) < hi) next_pack[i] = cur_bit;
    end
  end
endmodule

// File: rtl/rle_dec.sv
// Run-length decoder: reads 24-bit run words from an input FIFO, expands
// them into a bitstream and writes LSB-first packed bytes to an output FIFO.
// A partial tail byte is flushed on end_of_stream.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   recv_ready / rd_req   - input FIFO not-empty / one-cycle read pulse
//   in_data               - run word, valid the cycle after rd_req
//   send_ready / wr_req   - output FIFO not-full / one-cycle write pulse
//   out_data, out_bits    - written byte and its count of valid bits
//   end_of_stream, done   - stream end input / high while finished
module rle_dec
  import rle_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              recv_ready,
  input  logic              send_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              end_of_stream,
  output logic              rd_req,
  output logic              wr_req,
  output logic [BYTE_W-1:0] out_data,
  output logic [FILL_W-1:0] out_bits,
  output logic              done
);
  state_t            state, state_n;
  logic              cur_bit, cur_bit_n;
  logic [CNT_W-1:0]  remaining, remaining_n;
  logic [FILL_W-1:0] fill, fill_n;
  logic [BYTE_W-1:0] pack, pack_n;
  logic              rd_req_n, wr_req_n, flush_wr, flush_wr_n;
  logic [BYTE_W-1:0] out_data_n;
  logic [FILL_W-1:0] out_bits_n;

  logic [BYTE_W-1:0] pk_pack;
  logic [FILL_W-1:0] pk_fill;
  logic [CNT_W-1:0]  pk_rem;

  rle_bit_packer u_packer (
    .pack           (pack),
    .fill           (fill),
    .remaining      (remaining),
    .cur_bit        (cur_bit),
    .next_pack      (pk_pack),
    .next_fill      (pk_fill),
    .next_remaining (pk_rem)
  );

  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_bit   <= 1'b0;
      remaining <= '0;
      fill      <= '0;
      pack      <= '0;
      rd_req    <= 1'b0;
      wr_req    <= 1'b0;
      out_data  <= '0;
      out_bits  <= '0;
      flush_wr  <= 1'b0;
    end else begin
      state     <= state_n;
      cur_bit   <= cur_bit_n;
      remaining <= remaining_n;
      fill      <= fill_n;
      pack      <= pack_n;
      rd_req    <= rd_req_n;
      wr_req    <= wr_req_n;
      out_data  <= out_data_n;
      out_bits  <= out_bits_n;
      flush_wr  <= flush_wr_n;
    end
  end

  always_comb begin
    state_n     = state;
    cur_bit_n   = cur_bit;
    remaining_n = remaining;
    fill_n      = fill;
    pack_n      = pack;
    rd_req_n    = 1'b0;
    wr_req_n    = 1'b0;
    out_data_n  = out_data;
    out_bits_n  = out_bits;
    flush_wr_n  = flush_wr;
    case (state)
      IDLE: begin
        fill_n  = '0;
        pack_n  = '0;
        state_n = REQ;
      end
      REQ: begin
        if (recv_ready) begin
          rd_req_n = 1'b1;
          state_n  = WAIT;
        end else if (end_of_stream) begin
          state_n = (fill != '0) ? FLUSH : DONE;
        end
      end
      WAIT: state_n = LOAD;
      LOAD: begin
        cur_bit_n   = in_data[BIT_ID];
        remaining_n = in_data[CNT_MSB:0];
        // zero-length runs carry no bits; skip straight to the next word
        state_n     = (in_data[CNT_MSB:0] == '0) ? REQ : FILL;
      end
      FILL: begin
        pack_n      = pk_pack;
        fill_n      = pk_fill;
        remaining_n = pk_rem;
        if (pk_fill == FILL_W'(BYTE_W)) state_n = WRITE;
        else if (pk_rem == '0)          state_n = REQ;
      end
      WRITE, FLUSH: begin
        if (send_ready) begin
          out_data_n = pack;
          out_bits_n = fill;
          wr_req_n   = 1'b1;
          flush_wr_n = (state == FLUSH);
          state_n    = WACK;
        end
      end
      WACK: begin
        fill_n = '0;
        pack_n = '0;
        if (remaining != '0) state_n = FILL;
        else if (flush_wr)   state_n = DONE;
        else                 state_n = REQ;
      end
      DONE: if (!end_of_stream) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_rle_dec.sv
// Self-checking bench for rle_dec: a FIFO model feeds run words, a sink
// records writes, and a bit-level reference expands the runs into bytes.
module tb_rle_dec;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        recv_ready = 1'b0;
  logic        send_ready = 1'b1;
  logic [23:0] in_data = '0;
  logic        end_of_stream = 1'b0;
  logic        rd_req, wr_req, done;
  logic [7:0]  out_data;
  logic [3:0]  out_bits;

  rle_dec dut (
    .clk(clk), .rst(rst), .recv_ready(recv_ready), .send_ready(send_ready),
    .in_data(in_data), .end_of_stream(end_of_stream), .rd_req(rd_req),
    .wr_req(wr_req), .out_data(out_data), .out_bits(out_bits), .done(done)
  );

  always #5 clk = ~clk;

  int          n_vec = 0, n_err = 0;
  int          rd_cnt = 0;
  bit          rnd_bp = 1'b0, sr_force = 1'b1;
  logic [23:0] fifo[$];
  logic [23:0] words[$];
  logic [11:0] got[$];
  logic [11:0] exp_q[$];

  // FIFO with one cycle of read latency, plus output sink
  always @(negedge clk) begin
    if (wr_req) got.push_back({out_bits, out_data});
    if (rd_req) begin
      rd_cnt++;
      in_data = (fifo.size() != 0) ? fifo.pop_front() : 24'h0;
    end
    recv_ready = (fifo.size() != 0);
    send_ready = rnd_bp ? ($urandom_range(0, 9) < 7) : sr_force;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // expand runs into a flat bit list, then cut into LSB-first bytes
  task automatic build_exp();
    bit b[$];
    logic [7:0] v;
    int nb;
    exp_q.delete();
    foreach (words[i])
      for (int k = 0; k < int'(words[i][22:0]); k++) b.push_back(words[i][23]);
    while (b.size() >= 8) begin
      v = '0;
      for (int j = 0; j < 8; j++) v[j] = b.pop_front();
      exp_q.push_back({4'd8, v});
    end
    if (b.size() != 0) begin
      nb = b.size();
      v = '0;
      for (int j = 0; j < nb; j++) v[j] = b.pop_front();
      exp_q.push_back({4'(nb), v});
    end
  endtask

  task automatic start_stream();
    rst = 1'b1;
    end_of_stream = 1'b0;
    fifo.delete();
    tick();
    foreach (words[i]) fifo.push_back(words[i]);
    end_of_stream = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic run_stream(input string nm, output int base, output int rd0);
    int cyc;
    build_exp();
    start_stream();
    base = got.size();
    rd0  = rd_cnt;
    cyc  = 0;
    while (!done && cyc < 20000) begin
      tick();
      cyc++;
    end
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_nwr"}, got.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk({nm, "_wr"}, (base + i < got.size()) ? 32'(got[base + i]) : 32'hDEAD, 32'(exp_q[i]));
    end_of_stream = 1'b0;
    tick();
    chk({nm, "_done_clr"}, 32'(done), 32'd0);
  endtask

  initial begin
    int base, rd0, n, nb, run;
    logic [7:0] bytes[$];
    bit bits[$];
    bit cur;

    // reset state
    rst = 1'b1;
    tick(); tick();
    chk("rst_rd_req", 32'(rd_req), 0);
    chk("rst_wr_req", 32'(wr_req), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_bits", 32'(out_bits), 0);
    chk("rst_done", 32'(done), 0);

    // mid-byte boundary
    words = '{24'h000003, 24'h800005};
    run_stream("midbyte", base, rd0);
    chk("midbyte_const", (got.size() > base) ? 32'(got[base]) : 32'hDEAD, 32'h8F8);

    // long run spanning bytes with flushed tail
    words = '{24'h800014};
    run_stream("long", base, rd0);
    chk("long_tail", (got.size() >= base + 3) ? 32'(got[base + 2]) : 32'hDEAD, 32'h40F);

    // zero-length word discarded
    words = '{24'h800000, 24'h000008};
    run_stream("zero", base, rd0);
    chk("zero_const", (got.size() > base) ? 32'(got[base]) : 32'hDEAD, 32'h800);
    chk("zero_rdcnt", rd_cnt - rd0, 2);

    // backpressure in WRITE
    sr_force = 1'b0;
    words = '{24'h800008};
    start_stream();
    base = got.size();
    repeat (6) tick();
    for (int i = 0; i < 10; i++) chk("bp_hold", 32'(wr_req), 0);
    for (int i = 0; i < 10; i++) tick();
    chk("bp_still", got.size() - base, 0);
    sr_force = 1'b1;
    tick();
    chk("bp_wr", 32'(wr_req), 1);
    chk("bp_data", {out_bits, out_data}, 32'h8FF);
    repeat (4) tick();
    chk("bp_done", 32'(done), 1);
    end_of_stream = 1'b0;
    tick();

    // max count, reset after 100 bytes
    words = '{24'hFFFFFF};
    start_stream();
    base = got.size();
    n = 0;
    while (got.size() - base < 100 && n < 2000) begin
      tick();
      n++;
    end
    chk("max_100", 32'(got.size() - base >= 100), 1);
    chk("max_byte", (got.size() > base) ? 32'(got[base]) : 32'hDEAD, 32'h8FF);
    rst = 1'b1;
    end_of_stream = 1'b0;
    fifo.delete();
    tick();
    chk("max_rst_rd", 32'(rd_req), 0);
    chk("max_rst_wr", 32'(wr_req), 0);
    chk("max_rst_done", 32'(done), 0);
    rst = 1'b0;
    n = got.size();
    repeat (30) tick();
    chk("max_nowr", got.size() - n, 0);

    // random runs (including zero-length) with random backpressure
    rnd_bp = 1'b1;
    for (int t = 0; t < 12; t++) begin
      words.delete();
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++)
        words.push_back({1'($urandom_range(0, 1)), 23'($urandom_range(0, 20))});
      run_stream("rnd", base, rd0);
      chk("rnd_rdcnt", rd_cnt - rd0, n);
    end

    // round trip: random bytes run-length encoded by the bench
    for (int t = 0; t < 12; t++) begin
      bytes.delete();
      bits.delete();
      words.delete();
      nb = $urandom_range(1, 6);
      for (int i = 0; i < nb; i++) begin
        bytes.push_back(8'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 255)));
        for (int j = 0; j < 8; j++) bits.push_back(bytes[i][j]);
      end
      cur = bits[0];
      run = 0;
      foreach (bits[i]) begin
        if (bits[i] != cur) begin
          words.push_back({cur, 23'(run)});
          cur = bits[i];
          run = 0;
        end
        run++;
      end
      words.push_back({cur, 23'(run)});
      run_stream("trip", base, rd0);
      for (int i = 0; i < nb; i++)
        chk("trip_byte", (got.size() > base + i) ? 32'(got[base + i]) : 32'hDEAD, {20'd0, 4'd8, bytes[i]});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
